// File: rtl/gate_sweep_controller.sv
// gate_sweep_controller
//   Self-test sequencer for a two-input basic gates block. It steps {A,B}
//   through 00, 01, 10, 11. Each vector is held for HOLD_CYCLES settle cycles
//   before the seven gate outputs are sampled once and checked against the
//   built-in golden truth table.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a sweep (sampled only while idle)
//   abort      : synchronous cancel of a sweep in progress
//   gate_in    : observed gate outputs {AND,OR,NOT_A,NAND,NOR,XOR,XNOR}
//   a_out      : A input of the gates instance
//   b_out      : B input of the gates instance
//   busy       : high while a sweep is in progress
//   done       : one-cycle pulse when a sweep completes normally
//   pass       : last completed sweep had zero mismatches
//   err_count  : number of failing vectors in the last sweep (0..4)
//   fail_mask  : bit i set when vector {A,B}=i mismatched
//   first_fail : gate_in captured at the first mismatching vector
module gate_sweep_controller #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [6:0] gate_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask,
   output logic [6:0] first_fail
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t     state, state_next;
   logic [1:0] idx;
   logic [7:0] cnt;
   logic [6:0] golden;
   logic       mismatch;
   logic       accept;

   assign accept = start && !abort;

   // The vector index register drives A/B directly, so the last vector (11)
   // stays on the pins while idle after a sweep, and clearing the index on
   // abort or reset returns the pins to 00.
   assign a_out = idx[1];
   assign b_out = idx[0];

   always_comb begin
      golden = '0;
      case (idx)
         2'd0: golden = 7'b0011101;
         2'd1: golden = 7'b0111010;
         2'd2: golden = 7'b0101010;
         2'd3: golden = 7'b1100001;
         default: golden = '0;
      endcase
   end

   assign mismatch = (gate_in != golden);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept) state_next = ST_DRIVE;
         ST_DRIVE: begin
            if (abort)                  state_next = ST_IDLE;
            else if (cnt == HOLD_LAST)  state_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (abort)                  state_next = ST_IDLE;
            else if (idx == 2'd3)       state_next = ST_DONE;
            else                        state_next = ST_DRIVE;
         end
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_DRIVE, ST_SAMPLE: busy = 1'b1;
         ST_DONE:             done = 1'b1;
         default: ;
      endcase
   end

   // Sweep datapath: vector index, settle counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         cnt        <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= '0;
         first_fail <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  idx        <= '0;
                  cnt        <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_mask  <= '0;
                  first_fail <= '0;
               end
            end
            ST_DRIVE: begin
               if (abort) begin
                  idx  <= '0;
                  cnt  <= '0;
                  pass <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (abort) begin
                  idx  <= '0;
                  cnt  <= '0;
                  pass <= 1'b0;
               end else begin
                  if (mismatch) begin
                     fail_mask[idx] <= 1'b1;
                     err_count      <= err_count + 3'd1;
                     if (err_count == 3'd0) first_fail <= gate_in;
                  end
                  // pass must include the verdict of this final sample,
                  // which is not yet reflected in err_count.
                  if (idx == 2'd3) begin
                     pass <= (err_count == 3'd0) && !mismatch;
                  end else begin
                     idx <= idx + 2'd1;
                     cnt <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_controller.sv
module tb_gate_sweep_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, abort, start, sel;
   logic       start0, start1;
   logic [6:0] gin0, gin1;
   logic       a0, b0, busy0, done0, pass0;
   logic [2:0] ec0;
   logic [3:0] fm0;
   logic [6:0] ff0;
   logic       a1, b1, busy1, done1, pass1;
   logic [2:0] ec1;
   logic [3:0] fm1;
   logic [6:0] ff1;

   gate_sweep_controller #(.HOLD_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .gate_in(gin0),
      .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(ec0), .fail_mask(fm0), .first_fail(ff0));

   gate_sweep_controller #(.HOLD_CYCLES(1)) dut_h1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .gate_in(gin1),
      .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(ec1), .fail_mask(fm1), .first_fail(ff1));

   // Behavioural gates block with per-vector stuck-at-0 / stuck-at-1 faults
   logic [6:0] sa0 [4];
   logic [6:0] sa1 [4];

   function automatic logic [6:0] ideal(input logic a, input logic b);
      return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
   endfunction

   always_comb begin
      gin0 = (ideal(a0, b0) & ~sa0[{a0, b0}]) | sa1[{a0, b0}];
      gin1 = (ideal(a1, b1) & ~sa0[{a1, b1}]) | sa1[{a1, b1}];
   end

   // sel chooses which instance the sweep tasks exercise
   logic       oa, ob, obusy, odone, opass;
   logic [2:0] oec;
   logic [3:0] ofm;
   logic [6:0] off;
   always_comb begin
      start0 = sel ? 1'b0 : start;
      start1 = sel ? start : 1'b0;
      if (sel) {oa, ob, obusy, odone, opass, oec, ofm, off} = {a1, b1, busy1, done1, pass1, ec1, fm1, ff1};
      else     {oa, ob, obusy, odone, opass, oec, ofm, off} = {a0, b0, busy0, done0, pass0, ec0, fm0, ff0};
   end

   int pass_cnt = 0;
   int total    = 0;

   // Expected results of the most recent completed sweep
   logic [3:0] em;
   logic [2:0] ee;
   logic [6:0] ef;
   logic       ep;

   // Reference: walk the four vectors, compare the faulty observation with
   // the ideal gate function, accumulate results.
   function automatic void model(output logic [3:0] m, output logic [2:0] e,
                                 output logic [6:0] f, output logic p);
      logic [1:0] vv;
      logic [6:0] good, obs;
      m = '0; e = '0; f = '0;
      for (int v = 0; v < 4; v++) begin
         vv   = 2'(v);
         good = ideal(vv[1], vv[0]);
         obs  = (good & ~sa0[v]) | sa1[v];
         if (obs != good) begin
            if (e == 3'd0) f = obs;
            m[v] = 1'b1;
            e    = e + 3'd1;
         end
      end
      p = (e == 3'd0);
   endfunction

   task automatic clear_faults();
      for (int v = 0; v < 4; v++) begin
         sa0[v] = '0;
         sa1[v] = '0;
      end
   endtask

   // Full sweep on the selected instance with per-cycle checks
   task automatic run_sweep(input string name, input int hold, input bit restart_mid);
      int         t;
      logic [1:0] ev;
      logic [3:0] act4, exp4;
      logic [18:0] actr, expr;
      t = 4 * (hold + 1) + 1;
      model(em, ee, ef, ep);
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= t + 1; c++) begin
         @(negedge clk);
         start = (restart_mid && c == 7) ? 1'b1 : 1'b0;
         if (c < t) begin
            ev   = 2'((c - 1) / (hold + 1));
            act4 = {oa, ob, obusy, odone};
            exp4 = {ev, 1'b1, 1'b0};
            total++;
            if (act4 !== exp4)
               $display("FAIL %s cycle %0d {a,b,busy,done}: got %b expected %b", name, c, act4, exp4);
            else pass_cnt++;
         end else begin
            actr = {obusy, odone, opass, oec, ofm, off, oa, ob};
            expr = {1'b0, (c == t), ep, ee, em, ef, 2'b11};
            total++;
            if (actr !== expr)
               $display("FAIL %s cycle %0d {busy,done,pass,err,mask,first,a,b}: got %h expected %h",
                        name, c, actr, expr);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      total++;
      if ({a0, b0, busy0, done0, pass0, ec0, fm0, ff0, a1, b1, busy1, done1, pass1, ec1, fm1, ff1} !== '0)
         $display("FAIL reset outputs: got dut=%b_%h_%h_%h dut_h1=%b_%h_%h_%h expected all zero",
                  {a0, b0, busy0, done0, pass0}, ec0, fm0, ff0, {a1, b1, busy1, done1, pass1}, ec1, fm1, ff1);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clean_sweep();
      sel = 1'b0;
      clear_faults();
      run_sweep("clean", 4, 1'b0);
   endtask

   task automatic test_start_mid_sweep();
      sel = 1'b0;
      clear_faults();
      run_sweep("restart_ignored", 4, 1'b1);
   endtask

   task automatic test_start_abort_idle();
      logic [16:0] act, exp;
      sel = 1'b0;
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         act = {obusy, odone, opass, oec, ofm, oa, ob, off[6:4]};
         exp = {1'b0, 1'b0, ep, ee, em, 2'b11, ef[6:4]};
         total++;
         if (act !== exp)
            $display("FAIL start_abort_idle cycle %0d: got %h expected %h", c, act, exp);
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_xor_stuck();
      sel = 1'b0;
      clear_faults();
      for (int v = 0; v < 4; v++) sa0[v] = 7'b0000010;
      run_sweep("xor_stuck0", 4, 1'b0);
   endtask

   task automatic test_all_zero();
      sel = 1'b0;
      clear_faults();
      for (int v = 0; v < 4; v++) sa0[v] = 7'b1111111;
      run_sweep("all_zero", 4, 1'b0);
   endtask

   task automatic test_abort();
      logic [13:0] act, exp;
      int          dones;
      sel = 1'b0;
      clear_faults();
      sa1[0] = 7'b1000000;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 12) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      act = {obusy, odone, opass, oa, ob, oec, ofm, 2'b00};
      exp = {3'b000, 2'b00, 3'd1, 4'b0001, 2'b00};
      total++;
      if (act !== exp) $display("FAIL abort state: got %b expected %b", act, exp);
      else pass_cnt++;
      total++;
      if (off !== 7'b1011101) $display("FAIL abort first_fail: got %b expected %b", off, 7'b1011101);
      else pass_cnt++;
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (odone === 1'b1 || obusy === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) $display("FAIL abort no_resume: got %0d active cycles expected 0", dones);
      else pass_cnt++;
      clear_faults();
      run_sweep("after_abort", 4, 1'b0);
   endtask

   task automatic test_hold1();
      sel = 1'b1;
      clear_faults();
      run_sweep("hold1_clean", 1, 1'b0);
      sa0[2] = 7'b0000010;
      sa1[3] = 7'b0010000;
      run_sweep("hold1_fault", 1, 1'b0);
      sel = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         sel = 1'($urandom_range(0, 1));
         for (int v = 0; v < 4; v++) begin
            sa0[v] = 7'($urandom & $urandom & $urandom);
            sa1[v] = 7'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) begin
               sa0[v] = '0;
               sa1[v] = '0;
            end
         end
         run_sweep(sel ? "random_h1" : "random_h4", sel ? 1 : 4, 1'($urandom_range(0, 1)));
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int act_cycles;
      sel = 1'b0;
      sa0[1] = 7'b0100000;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({a0, b0, busy0, done0, pass0, ec0, fm0, ff0} !== '0)
         $display("FAIL reset_mid async: got %b_%h_%h_%h expected all zero",
                  {a0, b0, busy0, done0, pass0}, ec0, fm0, ff0);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      act_cycles = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (busy0 === 1'b1 || done0 === 1'b1 || {a0, b0} !== 2'b00) act_cycles++;
      end
      total++;
      if (act_cycles !== 0) $display("FAIL reset_mid no_resume: got %0d active cycles expected 0", act_cycles);
      else pass_cnt++;
      clear_faults();
   endtask

   initial begin
      test_reset();
      test_clean_sweep();
      test_start_mid_sweep();
      test_start_abort_idle();
      test_xor_stuck();
      test_all_zero();
      test_abort();
      test_hold1();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
